// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined bitwise/rotate logic unit with valid/ready on both sides.
// Result and zero flag are computed before stage 1 and shifted through STAGES registers.
// Optional macro LOGIC_UNIT_PARITY_EN adds the Logic_Parity output, piped with the data.
module logic_unit_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             CLK_logic,
  input  logic             RST_logic,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_logic,
  input  logic [WIDTH-1:0] B_logic,
  input  logic [2:0]       ALU_FUN_logic,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Logic_OUT,
  output logic             Logic_Flag,
  output logic             busy
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             Logic_Parity
`endif
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned LAST = STAGES - 1;

  logic [WIDTH-1:0]   result;
  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] rol_w;
  logic [2*WIDTH-1:0] ror_w;

  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  load;
  logic [STAGES-1:0]  drain;
  logic [WIDTH-1:0]   data_q [STAGES];
  logic [STAGES-1:0]  zero_q;
`ifdef LOGIC_UNIT_PARITY_EN
  logic [STAGES-1:0]  parity_q;
`endif

  // Operation decode; rotates use the doubled operand so amount 0 needs no special case.
  always_comb begin
    result = '0;
    amt    = B_logic[SHW-1:0];
    rol_w  = {A_logic, A_logic} << amt;
    ror_w  = {A_logic, A_logic} >> amt;
    unique case (ALU_FUN_logic)
      3'b000: result = A_logic & B_logic;
      3'b001: result = A_logic | B_logic;
      3'b010: result = ~(A_logic & B_logic);
      3'b011: result = ~(A_logic | B_logic);
      3'b100: result = A_logic ^ B_logic;
      3'b101: result = ~(A_logic ^ B_logic);
      3'b110: result = rol_w[2*WIDTH-1:WIDTH];
      3'b111: result = ror_w[WIDTH-1:0];
    endcase
  end

  // Drain/advance chain from the output back to the input, so a downstream accept frees a full pipe.
  always_comb begin
    drain       = '0;
    load        = '0;
    drain[LAST] = valid_q[LAST] & out_ready;
    for (int k = int'(LAST) - 1; k >= 0; k--) begin
      drain[k] = valid_q[k] & (~valid_q[k+1] | drain[k+1]);
    end
    in_ready = ~valid_q[0] | drain[0];
    load[0]  = in_valid & in_ready;
    for (int k = 1; k < int'(STAGES); k++) begin
      load[k] = valid_q[k-1] & (~valid_q[k] | drain[k]);
    end
  end

  // Stage registers: valid bits plus result, zero flag (and parity) travelling together.
  always_ff @(posedge CLK_logic or negedge RST_logic) begin
    if (!RST_logic) begin
      valid_q <= '0;
      zero_q  <= '0;
`ifdef LOGIC_UNIT_PARITY_EN
      parity_q <= '0;
`endif
      for (int k = 0; k < int'(STAGES); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (load[k]) begin
          valid_q[k] <= 1'b1;
        end else if (drain[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      if (load[0]) begin
        data_q[0] <= result;
        zero_q[0] <= (result == '0);
`ifdef LOGIC_UNIT_PARITY_EN
        parity_q[0] <= ^result;
`endif
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (load[k]) begin
          data_q[k] <= data_q[k-1];
          zero_q[k] <= zero_q[k-1];
`ifdef LOGIC_UNIT_PARITY_EN
          parity_q[k] <= parity_q[k-1];
`endif
        end
      end
    end
  end

  assign out_valid  = valid_q[LAST];
  assign Logic_OUT  = data_q[LAST];
  assign Logic_Flag = valid_q[LAST] & zero_q[LAST];
  assign busy       = |valid_q;
`ifdef LOGIC_UNIT_PARITY_EN
  assign Logic_Parity = parity_q[LAST];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=16): main STAGES=2 instance plus STAGES=1/4 latency instances.
module tb_logic_unit_pipe;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance signals
  logic         in_valid, in_ready, out_valid, out_ready, flag, busy;
  logic [W-1:0] a, b, res;
  logic [2:0]   fun;
`ifdef LOGIC_UNIT_PARITY_EN
  logic         par;
`endif

  // latency-instance signals (shared inputs, separate outputs)
  logic         x_valid;
  logic [W-1:0] x_a, x_b;
  logic [2:0]   x_fun;
  logic         r1_ready, o1_valid, f1, bz1;
  logic         r4_ready, o4_valid, f4, bz4;
  logic [W-1:0] o1, o4;
`ifdef LOGIC_UNIT_PARITY_EN
  logic         p1, p4;
`endif

  logic_unit_pipe #(.WIDTH(W), .STAGES(2)) dut (
    .CLK_logic(clk), .RST_logic(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A_logic(a), .B_logic(b), .ALU_FUN_logic(fun), .out_valid(out_valid),
    .out_ready(out_ready), .Logic_OUT(res), .Logic_Flag(flag), .busy(busy)
`ifdef LOGIC_UNIT_PARITY_EN
    , .Logic_Parity(par)
`endif
  );

  logic_unit_pipe #(.WIDTH(W), .STAGES(1)) dut1 (
    .CLK_logic(clk), .RST_logic(rst_n), .in_valid(x_valid), .in_ready(r1_ready),
    .A_logic(x_a), .B_logic(x_b), .ALU_FUN_logic(x_fun), .out_valid(o1_valid),
    .out_ready(1'b1), .Logic_OUT(o1), .Logic_Flag(f1), .busy(bz1)
`ifdef LOGIC_UNIT_PARITY_EN
    , .Logic_Parity(p1)
`endif
  );

  logic_unit_pipe #(.WIDTH(W), .STAGES(4)) dut4 (
    .CLK_logic(clk), .RST_logic(rst_n), .in_valid(x_valid), .in_ready(r4_ready),
    .A_logic(x_a), .B_logic(x_b), .ALU_FUN_logic(x_fun), .out_valid(o4_valid),
    .out_ready(1'b1), .Logic_OUT(o4), .Logic_Flag(f4), .busy(bz4)
`ifdef LOGIC_UNIT_PARITY_EN
    , .Logic_Parity(p4)
`endif
  );

  typedef struct {
    logic [W-1:0] val;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cnt = 0;
  bit   lat_mode = 1'b0;
  bit   stop_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: ops straight from the encoding table, rotates done bit by bit.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [2:0] f);
    logic [W-1:0] r;
    int amt;
    r   = '0;
    amt = int'(y) % int'(W);
    case (f)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = ~(x & y);
      3'd3: r = ~(x | y);
      3'd4: r = x ^ y;
      3'd5: r = ~(x ^ y);
      3'd6: for (int i = 0; i < int'(W); i++) r[(i + amt) % int'(W)] = x[i];
      default: for (int i = 0; i < int'(W); i++) r[i] = x[(i + amt) % int'(W)];
    endcase
    return r;
  endfunction

  // Issue one transaction (called at posedge+2); expected value is queued at the accepting cycle.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] tf,
                      input logic [W-1:0] exp, output int waits);
    exp_t e;
    bit   done;
    in_valid = 1'b1;
    a = ta; b = tb; fun = tf;
    waits = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.val = exp; e.acc_cyc = cyc; e.chk_lat = lat_mode;
        sb.push_back(e);
        accept_cnt++;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 200) begin
          fail("accept_timeout");
          done = 1'b1;
        end
      end
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand(output int waits);
    logic [W-1:0] ra, rb;
    logic [2:0]   rf;
    ra = W'($urandom);
    rb = W'($urandom);
    rf = 3'($urandom_range(0, 7));
    send(ra, rb, rf, ref_op(ra, rb, rf), waits);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) fail("drain_timeout");
  endtask

  // Monitor: compare presented result with scoreboard head; pop on transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        fail("unexpected_output");
      end else begin
        check("result", 32'(res), 32'(sb[0].val));
        check("zero_flag", 32'(flag), 32'(sb[0].val == '0));
`ifdef LOGIC_UNIT_PARITY_EN
        check("parity", 32'(par), 32'(^sb[0].val));
`endif
        if (out_ready) begin
          if (sb[0].chk_lat) check("latency", 32'(cyc - sb[0].acc_cyc), 32'd2);
          void'(sb.pop_front());
        end
      end
    end
  end

  // One transaction through the STAGES=1 and STAGES=4 instances, measuring latency in cycles.
  task automatic lat_test(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] tf,
                          input logic [W-1:0] exp);
    bit seen1, seen4;
    seen1 = 1'b0;
    seen4 = 1'b0;
    x_valid = 1'b1; x_a = ta; x_b = tb; x_fun = tf;
    @(negedge clk);
    check("s1_in_ready", 32'(r1_ready), 32'd1);
    check("s4_in_ready", 32'(r4_ready), 32'd1);
    @(posedge clk);
    #2;
    x_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (!seen1 && o1_valid) begin
        seen1 = 1'b1;
        check("s1_latency", 32'(n), 32'd1);
        check("s1_result", 32'(o1), 32'(exp));
      end
      if (!seen4 && o4_valid) begin
        seen4 = 1'b1;
        check("s4_latency", 32'(n), 32'd4);
        check("s4_result", 32'(o4), 32'(exp));
      end
    end
    if (!seen1) fail("s1_no_output");
    if (!seen4) fail("s4_no_output");
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ops_exp [8];
    int w;
    ops_exp = '{16'h00F0, 16'hFFF4, 16'hFF0F, 16'h000B, 16'hFF04, 16'h00FB, 16'h0F0F, 16'h0F0F};
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; fun = '0; out_ready = 1'b1;
    x_valid = 1'b0; x_a = '0; x_b = '0; x_fun = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(res), 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;

    // all ops on the reference operands, back to back
    lat_mode = 1'b1;
    for (int f = 0; f < 8; f++) send(16'hF0F0, 16'h0FF4, 3'(f), ops_exp[f], w);
    wait_empty();

    // zero flag
    send(16'hAAAA, 16'h5555, 3'd0, 16'h0000, w);
    send(16'hAAAA, 16'h5555, 3'd1, 16'hFFFF, w);
    wait_empty();

    // back-to-back throughput
    for (int i = 0; i < 8; i++) begin
      send_rand(w);
      check("burst_no_wait", 32'(w), 32'd0);
    end
    wait_empty();

    // rotate boundaries
    send(16'h8001, 16'hFFF0, 3'd6, 16'h8001, w);
    send(16'h8001, 16'h0001, 3'd7, 16'hC000, w);
    wait_empty();

    // backpressure
    lat_mode = 1'b0;
    out_ready = 1'b0;
    accept_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand(w);
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        check("bp_accepts", 32'(accept_cnt), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    wait_empty();
    check("bp_total", 32'(accept_cnt), 32'd6);

    // reset with two results in flight
    out_ready = 1'b0;
    send(16'h1234, 16'h00FF, 3'd0, 16'h0034, w);
    send(16'h1234, 16'h00FF, 3'd1, 16'h12FF, w);
    check("inflight_busy", 32'(busy), 32'd1);
    check("inflight_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", 32'(res), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_flag", 32'(flag), 32'd0);
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    lat_mode = 1'b1;
    send(16'hF0F0, 16'h0FF4, 3'd4, 16'hFF04, w);
    wait_empty();

    // randomized traffic with random downstream stalls
    lat_mode = 1'b0;
    stop_rand = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send_rand(w);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #2;
          end
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_empty();

    // latency and rotate boundaries at STAGES=1 and STAGES=4
    lat_test(16'h8001, 16'hFFF0, 3'd6, 16'h8001);
    lat_test(16'h8001, 16'h0001, 3'd7, 16'hC000);
    lat_test(16'hF0F0, 16'h0FF4, 3'd6, 16'h0F0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
